// File: rtl/vec_pkg.sv
// Shared vector-register constants and the physical-to-architectural index mapping.
// Used by vec_wb_fifo and vec_wb_reg_encode.
package vec_pkg;
  localparam int unsigned VBASE  = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned PIDX_W = 5;

  typedef logic [PIDX_W-1:0] vreg_pidx_t;

  // Architectural rd = base + physical index, kept to the 5-bit register-number field.
  function automatic vreg_pidx_t pidx_to_arch(input vreg_pidx_t pidx, input int unsigned base);
    return pidx + vreg_pidx_t'(base);
  endfunction
endpackage

// File: rtl/vec_wb_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is visible on rdata while not empty.
// flush empties the FIFO and overrides any push or pop in the same cycle.
module vec_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 133
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  mem [DEPTH];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/vec_wb_reg_encode.sv
// Vector writeback encoder: buffers physical-index results, emits architectural rd, tracks pending writes.
// Optional VEC_WB_BYPASS_EN: zero-latency pass-through of a legal input while the FIFO is empty.
module vec_wb_reg_encode
  import vec_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NREGS  = vec_pkg::NREGS,
  parameter int VBASE  = vec_pkg::VBASE,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_pidx,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [NREGS-1:0]  busy,
  output logic              err_illegal
);
  localparam int PW = $clog2(DEPTH+1);
  localparam int W  = PIDX_W + DATA_W;
  localparam logic [PIDX_W:0] NREGS_L = (PIDX_W+1)'(NREGS);

  // Handshake: a transfer happens on a cycle where valid && ready; valid never depends on ready.
  logic             full, empty, push, pop, legal;
  logic [W-1:0]     head;
  vreg_pidx_t       head_pidx;
  logic [PW-1:0]    pend [NREGS];

  assign head_pidx = head[W-1 -: PIDX_W];
  assign legal     = ({1'b0, in_pidx} < NREGS_L);
  assign in_ready  = !full;
  assign pop       = !empty && out_ready;

`ifdef VEC_WB_BYPASS_EN
  logic bypass;
  assign bypass    = empty && in_valid && legal;
  // A bypassed result consumed this cycle never enters the FIFO or the scoreboard.
  assign push      = in_valid && in_ready && legal && !(bypass && out_ready);
  assign out_valid = !empty || bypass;
  assign out_rd    = bypass ? pidx_to_arch(in_pidx, VBASE) : pidx_to_arch(head_pidx, VBASE);
  assign out_data  = bypass ? in_data : head[DATA_W-1:0];
`else
  assign push      = in_valid && in_ready && legal;
  assign out_valid = !empty;
  assign out_rd    = pidx_to_arch(head_pidx, VBASE);
  assign out_data  = head[DATA_W-1:0];
`endif

  vec_wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({in_pidx, in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Enqueue and dequeue of the same register in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) pend[i] <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= in_valid && !legal;
      for (int i = 0; i < NREGS; i++) begin
        if (flush) pend[i] <= '0;
        else pend[i] <= pend[i] + PW'(push && (in_pidx == vreg_pidx_t'(i)))
                                - PW'(pop && (head_pidx == vreg_pidx_t'(i)));
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NREGS; i++) busy[i] = (pend[i] != '0);
  end
endmodule

// File: tb/tb_vec_wb_reg_encode.sv
// Directed table-driven bench for vec_wb_reg_encode plus hand-written reset, latency and bypass sequences.
// Each table row is driven after a falling edge and checked 1ns later, before the next rising edge.
module tb_vec_wb_reg_encode;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   in_pidx = '0;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [4:0]   out_rd;
  logic [127:0] out_data;
  logic [7:0]   busy;
  logic         err_illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic         iv;
    logic [4:0]   pidx;
    logic [127:0] d;
    logic         ordy;
    logic         fl;
    logic         e_ov;
    logic         dc;     // out_valid differs between bypass/non-bypass builds on this row
    logic [4:0]   e_rd;
    logic [127:0] e_d;
    logic [7:0]   e_busy;
    logic         e_irdy;
    logic         e_err;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  vec_wb_reg_encode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pidx     (in_pidx),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_data    (out_data),
    .busy        (busy),
    .err_illegal (err_illegal)
  );

  function automatic logic [127:0] dv(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(n);
    return {w, w, w, w};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [4:0] pidx, input logic [127:0] d, input logic ordy,
                     input logic fl, input logic e_ov, input logic dc, input logic [4:0] e_rd,
                     input logic [127:0] e_d, input logic [7:0] e_busy, input logic e_irdy,
                     input logic e_err);
    vec_t r;
    r = '{iv, pidx, d, ordy, fl, e_ov, dc, e_rd, e_d, e_busy, e_irdy, e_err};
    tbl.push_back(r);
  endtask

  task automatic drive(input logic iv, input logic [4:0] pidx, input logic [127:0] d,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_pidx   = pidx;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    // Reset behaviour while rst_n is held low
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_busy", 128'(busy), 128'(8'h00));
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset_err", 128'(err_illegal), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // iv pidx data ordy fl | e_ov dc e_rd e_data busy irdy err
    add(0, 0, '0,     0, 0,  0, 0, 0,  '0,     8'h00, 1, 0);
    add(1, 0, dv(0),  0, 0,  0, 1, 0,  '0,     8'h00, 1, 0);
    add(1, 1, dv(1),  0, 0,  1, 0, 16, dv(0),  8'h01, 1, 0);
    add(1, 2, dv(2),  0, 0,  1, 0, 16, dv(0),  8'h03, 1, 0);
    add(1, 0, dv(3),  0, 0,  1, 0, 16, dv(0),  8'h07, 1, 0);
    add(0, 0, '0,     0, 0,  1, 0, 16, dv(0),  8'h07, 0, 0);
    add(1, 5, dv(9),  0, 0,  1, 0, 16, dv(0),  8'h07, 0, 0);
    add(0, 0, '0,     1, 0,  1, 0, 16, dv(0),  8'h07, 0, 0);
    add(0, 0, '0,     1, 0,  1, 0, 17, dv(1),  8'h07, 1, 0);
    add(0, 0, '0,     1, 0,  1, 0, 18, dv(2),  8'h05, 1, 0);
    add(0, 0, '0,     1, 0,  1, 0, 16, dv(3),  8'h01, 1, 0);
    add(0, 0, '0,     1, 0,  0, 0, 0,  '0,     8'h00, 1, 0);
    add(1, 9, dv(10), 1, 0,  0, 0, 0,  '0,     8'h00, 1, 0);
    add(0, 0, '0,     1, 0,  0, 0, 0,  '0,     8'h00, 1, 1);
    add(0, 0, '0,     1, 0,  0, 0, 0,  '0,     8'h00, 1, 0);
    add(1, 4, dv(4),  0, 0,  0, 1, 0,  '0,     8'h00, 1, 0);
    add(1, 4, dv(5),  1, 0,  1, 0, 20, dv(4),  8'h10, 1, 0);
    add(1, 6, dv(6),  1, 0,  1, 0, 20, dv(5),  8'h10, 1, 0);
    add(0, 0, '0,     1, 0,  1, 0, 22, dv(6),  8'h40, 1, 0);
    add(0, 0, '0,     1, 0,  0, 0, 0,  '0,     8'h00, 1, 0);
    add(1, 1, dv(7),  0, 0,  0, 1, 0,  '0,     8'h00, 1, 0);
    add(1, 2, dv(8),  0, 0,  1, 0, 17, dv(7),  8'h02, 1, 0);
    add(1, 3, dv(11), 0, 1,  1, 0, 17, dv(7),  8'h06, 1, 0);
    add(0, 0, '0,     0, 0,  0, 0, 0,  '0,     8'h00, 1, 0);
    add(1, 5, dv(12), 0, 0,  0, 1, 0,  '0,     8'h00, 1, 0);
    add(0, 0, '0,     1, 0,  1, 0, 21, dv(12), 8'h20, 1, 0);
    add(0, 0, '0,     1, 0,  0, 0, 0,  '0,     8'h00, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].pidx, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      #1;
      if (!tbl[i].dc) begin
        chk($sformatf("row%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
        if (tbl[i].e_ov) begin
          chk($sformatf("row%0d_out_rd", i), 128'(out_rd), 128'(tbl[i].e_rd));
          chk($sformatf("row%0d_out_data", i), out_data, tbl[i].e_d);
        end
      end
      chk($sformatf("row%0d_busy", i), 128'(busy), 128'(tbl[i].e_busy));
      chk($sformatf("row%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].e_irdy));
      chk($sformatf("row%0d_err", i), 128'(err_illegal), 128'(tbl[i].e_err));
    end

`ifdef VEC_WB_BYPASS_EN
    // Empty FIFO, legal input with out_ready: same-cycle writeback, nothing stored
    @(negedge clk);
    drive(1, 7, dv(20), 1, 0);
    #1;
    chk("byp_out_valid", 128'(out_valid), 128'(1'b1));
    chk("byp_out_rd", 128'(out_rd), 128'(5'd23));
    chk("byp_out_data", out_data, dv(20));
    @(negedge clk);
    drive(0, 0, '0, 1, 0);
    #1;
    chk("byp_after_valid", 128'(out_valid), 128'(1'b0));
    chk("byp_after_busy", 128'(busy), 128'(8'h00));
`else
    // Single write with out_ready high: visible one cycle later, then drained
    @(negedge clk);
    drive(1, 3, dv(30), 1, 0);
    #1;
    chk("lat_same_cycle_valid", 128'(out_valid), 128'(1'b0));
    @(negedge clk);
    drive(0, 0, '0, 1, 0);
    #1;
    chk("lat_out_valid", 128'(out_valid), 128'(1'b1));
    chk("lat_out_rd", 128'(out_rd), 128'(5'd19));
    chk("lat_out_data", out_data, dv(30));
    chk("lat_busy", 128'(busy), 128'(8'h08));
    @(negedge clk);
    #1;
    chk("lat_drained_valid", 128'(out_valid), 128'(1'b0));
    chk("lat_drained_busy", 128'(busy), 128'(8'h00));
`endif

    // Asynchronous reset with writes buffered
    @(negedge clk);
    drive(1, 2, dv(40), 0, 0);
    @(negedge clk);
    drive(1, 3, dv(41), 0, 0);
    @(negedge clk);
    drive(0, 0, '0, 0, 0);
    #1;
    chk("pre_rst_busy", 128'(busy), 128'(8'h0C));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("mid_rst_busy", 128'(busy), 128'(8'h00));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_out_valid", 128'(out_valid), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
